// File: rtl/e203_itcm_loader_if.sv
// ---------------------------------------------------------------------------
// e203_itcm_loader_if
// Single-port SRAM bus used on both sides of the ITCM loader: the core's
// ITCM request port and the port to the ITCM RAM macro.
//   cs   : chip select, one access per cycle while high
//   we   : 1 = write, 0 = read
//   addr : 64-bit word address
//   wem  : byte write-enables (bit n covers din[8n+7:8n])
//   din  : write data
//   dout : read data, valid the cycle after a read access
// Modports:
//   master : the requester (drives cs/we/addr/wem/din, receives dout)
//   slave  : the responder (receives the request, drives dout)
// ---------------------------------------------------------------------------
interface e203_itcm_loader_if #(
  parameter int AW = 13,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [MW-1:0] wem;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output cs, we, addr, wem, din, input dout);
  modport slave  (input cs, we, addr, wem, din, output dout);
endinterface

// File: rtl/e203_itcm_loader.sv
// ---------------------------------------------------------------------------
// e203_itcm_loader
// Backdoor loader and arbiter for the ITCM SRAM. Packs a little-endian byte
// stream into 64-bit words and writes them to ITCM words 0..len-1, holding
// the core off the RAM (core_hold) until the load completes.
//
// Optional feature macro: E203_ITCM_LOADER_CHKSUM_EN
//   defined   : one trailer byte follows the payload; trailer + sum(payload)
//               must be 0 mod 256, otherwise ld_err is set and core_hold
//               stays asserted.
//   undefined : no trailer, ld_err tied to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_start, ld_len  start pulse and word count (0 = release only)
//   ld_byte_valid/ld_byte/ld_byte_ready  byte stream
//   cpu_ram (slave)   core ITCM port; cpu_ram_gnt = access granted
//   ram (master)      ITCM RAM macro port (1-cycle read latency)
//   core_hold         holds the core while high
//   ld_busy, ld_done, ld_word_cnt, ld_err  load status
//   dbg_state         current FSM state
//
// Byte handshake: a byte transfers on a rising clk edge where ld_byte_valid
// and ld_byte_ready are both high; the source may change ld_byte freely
// while valid is low, and ready never depends on valid.
// ---------------------------------------------------------------------------
module e203_itcm_loader #(
  parameter int AW = 13,
  parameter int DW = 64,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_byte_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_byte_ready,
  e203_itcm_loader_if.slave  cpu_ram,
  output logic          cpu_ram_gnt,
  e203_itcm_loader_if.master ram,
  output logic          core_hold,
  output logic          ld_busy,
  output logic          ld_done,
  output logic [AW:0]   ld_word_cnt,
  output logic          ld_err,
  output logic [2:0]    dbg_state
);

  generate
    if (DW != 64 || MW != DW / 8) begin : g_bad_cfg
      $error("e203_itcm_loader: DW must be 64 and MW must be DW/8");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACK  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef E203_ITCM_LOADER_CHKSUM_EN
    ST_CHK   = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_e;

  // Largest legal length: the whole ITCM. Anything above is clamped so the
  // write address never wraps back onto word 0.
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] pack_q, pack_d;
  logic          hold_q, hold_d;
  logic [AW:0]   cnt_inc;
  logic          wr_en;

`ifdef E203_ITCM_LOADER_CHKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic [7:0]    chk_total;

  assign chk_total = ld_byte + sum_q;
  assign ld_err    = err_q;
`else
  assign ld_err    = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    pack_d        = pack_q;
    hold_d        = hold_q;
    ld_byte_ready = 1'b0;
    ld_done       = 1'b0;
    wr_en         = 1'b0;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
    sum_d         = sum_q;
    err_d         = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
`ifdef E203_ITCM_LOADER_CHKSUM_EN
          err_d = 1'b0;
`endif
          if (ld_len == '0) begin
            // Release: no data, just drop core_hold.
            state_d = ST_DONE;
          end else begin
            len_d   = ld_len[AW] ? LEN_MAX : ld_len;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
            sum_d   = '0;
`endif
            state_d = ST_PACK;
          end
        end
      end

      ST_PACK: begin
        ld_byte_ready = 1'b1;
        if (ld_byte_valid) begin
          pack_d[{idx_q, 3'b000} +: 8] = ld_byte;
          idx_d = idx_q + 3'd1;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
          sum_d = sum_q + ld_byte;
`endif
          if (idx_q == 3'd7) state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        wr_en = 1'b1;
        cnt_d = cnt_inc;
        idx_d = '0;
        if (cnt_inc == len_q) begin
`ifdef E203_ITCM_LOADER_CHKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_PACK;
        end
      end

`ifdef E203_ITCM_LOADER_CHKSUM_EN
      ST_CHK: begin
        ld_byte_ready = 1'b1;
        if (ld_byte_valid) begin
          if (chk_total != 8'h00) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        ld_done = 1'b1;
        // A failed checksum keeps the core held.
        if (!ld_err) hold_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      hold_q  <= 1'b1;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      hold_q  <= hold_d;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ld_busy     = (state_q != ST_IDLE);
  assign core_hold   = hold_q;
  assign ld_word_cnt = cnt_q;
  assign dbg_state   = state_q;

  // RAM arbitration: the loader owns the macro for the whole load; core
  // requests in that window are dropped, not queued.
  always_comb begin
    if (ld_busy) begin
      ram.cs   = wr_en;
      ram.we   = wr_en;
      ram.addr = cnt_q[AW-1:0];
      ram.wem  = {MW{wr_en}};
      ram.din  = pack_q;
    end else begin
      ram.cs   = cpu_ram.cs;
      ram.we   = cpu_ram.we;
      ram.addr = cpu_ram.addr;
      ram.wem  = cpu_ram.wem;
      ram.din  = cpu_ram.din;
    end
  end

  assign cpu_ram_gnt  = cpu_ram.cs && !ld_busy;
  assign cpu_ram.dout = ram.dout;

endmodule

// File: doc/e203_itcm_loader.md
Name: e203_itcm_loader

Overview:
- Backdoor loader and arbiter for the ITCM SRAM, sitting between the core's ITCM SRAM port and the ITCM RAM macro.
- Accepts a little-endian byte stream, packs bytes into 64-bit words, and writes them sequentially from ITCM word 0.
- Holds the core off the RAM and keeps `core_hold` asserted until the load completes.
- Replaces simulation-only hierarchical preload, so silicon and FPGA builds can boot from an external byte source.

Parameters:
- AW, 13, ITCM word-address width (64 KB of 64-bit words).
- DW, 64, RAM data width; fixed at 64. Any other value is a compile-time error.
- MW, 8, byte write-enable width (DW/8).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ld_start  in  1  single-cycle pulse that starts a load
- ld_len  in  AW+1  number of 64-bit words to load; sampled on ld_start
- ld_byte_valid  in  1  stream byte valid
- ld_byte  in  8  stream byte
- ld_byte_ready  out  1  stream byte accepted when valid and ready are both high
- cpu_ram_cs  in  1  core RAM chip select
- cpu_ram_we  in  1  core RAM write
- cpu_ram_addr  in  AW  core RAM word address
- cpu_ram_wem  in  MW  core byte write-enables
- cpu_ram_din  in  DW  core write data
- cpu_ram_dout  out  DW  read data to core
- cpu_ram_gnt  out  1  core access granted this cycle
- ram_cs  out  1  to RAM macro
- ram_we  out  1  to RAM macro
- ram_addr  out  AW  to RAM macro
- ram_wem  out  MW  to RAM macro
- ram_din  out  DW  to RAM macro
- ram_dout  in  DW  from RAM macro (1-cycle read latency)
- core_hold  out  1  keeps the core in reset/stall while high
- ld_busy  out  1  load in progress
- ld_done  out  1  one-cycle pulse when a load completes
- ld_word_cnt  out  AW+1  words written so far
- ld_err  out  1  checksum error, sticky until next ld_start (see Optional Feature)

Behaviour:
- Reset values:
  - state = IDLE.
  - ld_byte_ready, ld_busy, ld_done, ld_err = 0; ram_cs = 0.
  - ld_word_cnt = 0; byte index = 0; pack register = 0.
  - core_hold = 1: the core stays held after reset until the first load finishes or `release` occurs.
- Release: ld_start with ld_len = 0 is a release. It produces one DONE cycle and drops core_hold with no RAM writes.
- FSM states: IDLE, PACK, WRITE, (CHK), DONE.
- IDLE:
  - On ld_start with ld_len != 0: latch ld_len, clear ld_word_cnt, byte index and ld_err, then go to PACK.
  - On ld_start with ld_len == 0: go to DONE.
- PACK:
  - ld_byte_ready = 1.
  - An accepted byte is placed in bits [8*idx+7 : 8*idx] of the pack register, then idx increments.
  - When byte 7 is accepted, go to WRITE on the next cycle.
  - While ld_byte_valid = 0, hold state indefinitely; there is no timeout.
- WRITE (exactly 1 cycle):
  - ld_byte_ready = 0.
  - ram_cs = 1, ram_we = 1, ram_wem = all ones, ram_addr = ld_word_cnt[AW-1:0], ram_din = pack register.
  - ld_word_cnt increments.
  - If the new count equals the latched length, go to CHK when the checksum feature is compiled in, otherwise DONE. Otherwise return to PACK with idx = 0.
- DONE (1 cycle):
  - ld_done = 1.
  - core_hold deasserts on the following cycle and stays 0 until reset.
  - Return to IDLE.
- ld_busy is 1 in every state except IDLE.
- ld_start while ld_busy = 1 is ignored.
- Arbitration and data path:
  - While ld_busy = 1, the loader owns the RAM and cpu_ram_gnt = 0. Core requests are dropped, not queued; core_hold guarantees none are expected.
  - When not busy, the core's RAM signals pass straight through to the RAM combinationally and cpu_ram_gnt = cpu_ram_cs.
  - cpu_ram_dout = ram_dout at all times.
- Address rules: ld_len maximum is 2^AW. Values larger than that are clamped to 2^AW, and the address never wraps.
- Reset mid-load: the FSM returns to IDLE, the partial word is discarded, words already written remain in RAM, and core_hold returns to 1.

Optional Feature:
- Macro: E203_ITCM_LOADER_CHKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) is kept over all payload bytes.
  - After the last WRITE the FSM enters CHK with ld_byte_ready = 1 and accepts one trailer byte.
  - If trailer + sum != 8'h00, ld_err = 1.
  - The FSM then goes to DONE, and core_hold is released only if ld_err = 0.
- Disabled: there is no CHK state and no trailer byte; ld_err is tied to 0.

Test Plan:
- Reset, then ld_start with ld_len = 2 and bytes 00..0F streamed back-to-back -> RAM word0 = 64'h0706050403020100, word1 = 64'h0F0E0D0C0B0A0908; two WRITE cycles; ld_done pulses once; core_hold = 0 on the cycle after DONE.
- Same load with ld_byte_valid toggling every other cycle -> identical RAM contents; ld_word_cnt steps 0 -> 1 -> 2 only on WRITE cycles.
- ld_start with ld_len = 0 -> ld_done pulses 1 cycle after start; no ram_cs; core_hold drops.
- Core asserts cpu_ram_cs during a load -> cpu_ram_gnt = 0 and the RAM sees loader traffic only. After DONE, a core read of address 1 returns 64'h0F0E0D0C0B0A0908 one cycle later.
- rst_n pulsed low after 3 bytes of word 1 -> state IDLE, core_hold = 1; word0 is intact and word1 is unwritten. A second ld_start is accepted normally.
- With CHKSUM_EN: ld_len = 1, bytes 01..08 (sum 8'h24), trailer 8'hDC -> ld_err = 0 and hold released. With trailer 8'h00 -> ld_err = 1 and core_hold stays 1.
